// File: rtl/soc_system_pio_status_done.sv
// Avalon-MM input PIO with synchronizer, edge capture (W1C) and a level IRQ for accelerator done lines.
// Optional feature macro: SOC_PIO_DONE_IRQ_EN (IRQMASK register and irq logic; otherwise irq tied low).
module soc_system_pio_status_done #(
  parameter int unsigned DATA_WIDTH  = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  localparam int unsigned ARM_W    = 3;
  localparam int unsigned RD_W     = 32;
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_DIR     = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q, sync_d;
  logic [DATA_WIDTH-1:0]                  prev_q, prev_d;
  logic [ARM_W-1:0]                       arm_q, arm_d;
  logic [DATA_WIDTH-1:0]                  edgecap_q, edgecap_d;
  logic [RD_W-1:0]                        readdata_q, readdata_d;
  logic                                   irq_q, irq_d;
`ifdef SOC_PIO_DONE_IRQ_EN
  logic [DATA_WIDTH-1:0]                  irqmask_q, irqmask_d;
`endif

  logic                  wr_c;
  logic                  armed_c;
  logic [DATA_WIDTH-1:0] wdata_c;
  logic [DATA_WIDTH-1:0] synced_c;
  logic [DATA_WIDTH-1:0] rise_c;
  logic [DATA_WIDTH-1:0] fall_c;
  logic [DATA_WIDTH-1:0] edge_det_c;
  logic                  unused_c;

  assign wr_c     = chipselect & ~write_n;
  assign wdata_c  = writedata[DATA_WIDTH-1:0];
  assign synced_c = sync_q[SYNC_STAGES-1];
  assign armed_c  = (arm_q == ARM_DONE);
  assign unused_c = ^writedata;

  // Synchronizer chain, previous-value register and post-reset arm counter
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = in_port;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = synced_c;
    arm_d  = armed_c ? arm_q : arm_q + ARM_W'(1);
  end

  // Edge selection; suppressed until the sync chain holds post-reset samples
  always_comb begin
    rise_c     = synced_c & ~prev_q;
    fall_c     = ~synced_c & prev_q;
    edge_det_c = '0;
    if (armed_c) begin
      case (EDGE_TYPE)
        0:       edge_det_c = rise_c;
        1:       edge_det_c = fall_c;
        default: edge_det_c = rise_c | fall_c;
      endcase
    end
  end

  // Edge capture: W1C clear, a same-cycle edge wins over the clear
  always_comb begin
    edgecap_d = edgecap_q;
    if (wr_c && (address == ADDR_EDGECAP)) begin
      edgecap_d = edgecap_q & ~wdata_c;
    end
    edgecap_d = edgecap_d | edge_det_c;
  end

`ifdef SOC_PIO_DONE_IRQ_EN
  always_comb begin
    irqmask_d = irqmask_q;
    if (wr_c && (address == ADDR_IRQMASK)) begin
      irqmask_d = wdata_c;
    end
    irq_d = |(edgecap_q & irqmask_q);
  end
`else
  always_comb begin
    irq_d = 1'b0;
  end
`endif

  // Registered read mux, fixed one-cycle latency, no side effects
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:    readdata_d = RD_W'(synced_c);
      ADDR_DIR:     readdata_d = '0;
`ifdef SOC_PIO_DONE_IRQ_EN
      ADDR_IRQMASK: readdata_d = RD_W'(irqmask_q);
`else
      ADDR_IRQMASK: readdata_d = '0;
`endif
      ADDR_EDGECAP: readdata_d = RD_W'(edgecap_q);
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      prev_q     <= '0;
      arm_q      <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
`ifdef SOC_PIO_DONE_IRQ_EN
      irqmask_q  <= '0;
`endif
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      arm_q      <= arm_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
`ifdef SOC_PIO_DONE_IRQ_EN
      irqmask_q  <= irqmask_d;
`endif
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_soc_system_pio_status_done.sv
// Directed + randomized bench for soc_system_pio_status_done against a history-based reference model.
module tb_soc_system_pio_status_done;

  localparam int unsigned DW = 4;
  localparam int unsigned SS = 2;
  localparam int unsigned ET = 0;
`ifdef SOC_PIO_DONE_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [DW-1:0] in_port;
  logic [31:0]   readdata;
  logic          irq;

  always #5 clk = ~clk;

  soc_system_pio_status_done #(
    .DATA_WIDTH (DW),
    .SYNC_STAGES(SS),
    .EDGE_TYPE  (ET)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: in_port history per clock edge; synced value is the sample SS edges old
  logic [DW-1:0] hist[$];
  int unsigned   k;
  logic [DW-1:0] m_ecap;
  logic [DW-1:0] m_mask;
  logic [31:0]   m_rd;
  logic          m_irq;
  logic [DW-1:0] cur_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < int'(SS) + 1; i++) hist.push_back('0);
    k      = 0;
    m_ecap = '0;
    m_mask = '0;
    m_rd   = '0;
    m_irq  = 1'b0;
  endtask

  task automatic model_edge();
    logic [DW-1:0] sb, pb, det;
    bit wr;
    if (reset) begin
      model_reset();
      return;
    end
    sb  = hist[hist.size() - SS];
    pb  = hist[hist.size() - SS - 1];
    det = '0;
    if (k >= SS + 1) begin
      if (ET == 0)      det = sb & ~pb;
      else if (ET == 1) det = ~sb & pb;
      else              det = sb ^ pb;
    end
    case (address)
      2'd0:    m_rd = 32'(sb);
      2'd2:    m_rd = 32'(m_mask);
      2'd3:    m_rd = 32'(m_ecap);
      default: m_rd = '0;
    endcase
    m_irq = IRQ_EN && (|(m_ecap & m_mask));
    wr = chipselect && !write_n;
    if (wr && address == 2'd2 && IRQ_EN) m_mask = writedata[DW-1:0];
    if (wr && address == 2'd3)           m_ecap = m_ecap & ~writedata[DW-1:0];
    m_ecap = m_ecap | det;
    hist.push_back(in_port);
    if (hist.size() > SS + 2) void'(hist.pop_front());
    k++;
  endtask

  // One clock: drive at negedge, advance model at posedge, compare at next negedge
  task automatic cyc(input logic rst, input logic cs, input logic wn,
                     input logic [1:0] a, input logic [31:0] wd);
    reset      = rst;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    in_port    = cur_in;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("readdata", readdata, m_rd);
    check("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 2'd0, 32'h0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [1:0] a);
    cyc(1'b0, 1'b1, 1'b1, a, 32'h0);
  endtask

  initial begin
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    cur_in = 4'hF; in_port = cur_in;
    model_reset();

    // Reset with lines high: arm counter suppresses the apparent edge
    cyc(1'b1, 1'b0, 1'b1, 2'd0, 32'h0);
    cyc(1'b1, 1'b0, 1'b1, 2'd0, 32'h0);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    idle(10);
    rd(2'd3); check("t1_edgecap", readdata, 32'h0);
    rd(2'd0); check("t1_data", readdata, 32'hF);
    rd(2'd1); check("t1_dir", readdata, 32'h0);
    check("t1_irq", 32'(irq), 32'h0);
    cur_in = 4'h0; idle(5);
    rd(2'd3); check("t1_fall_ignored", readdata, 32'h0);

    // Mask bit 1 only: edge on bit 0 captured without irq, then bit 1 raises irq
    wr(2'd2, 32'h2);
    rd(2'd2); check("t4_mask", readdata, IRQ_EN ? 32'h2 : 32'h0);
    cur_in = 4'h1; idle(5);
    rd(2'd3); check("t4_ecap_b0", readdata, 32'h1);
    check("t4_irq_b0", 32'(irq), 32'h0);
    cur_in = 4'h3; idle(5);
    rd(2'd3); check("t4_ecap_b01", readdata, 32'h3);
    check("t4_irq_b1", 32'(irq), 32'(IRQ_EN));
    wr(2'd3, 32'h3); idle(2);
    rd(2'd3); check("t2_w1c", readdata, 32'h0);
    check("t2_irq_clr", 32'(irq), 32'h0);

    // Same-cycle W1C and detected rising edge on bit 0: set wins
    cur_in = 4'h2; idle(4);
    wr(2'd3, 32'hF); wr(2'd2, 32'h1); idle(2);
    cur_in = 4'h3;
    idle(2);
    wr(2'd3, 32'h1);
    rd(2'd3); check("t3_set_wins", readdata, 32'h1);
    check("t3_irq", 32'(irq), 32'(IRQ_EN));
    idle(1); check("t3_irq_hold", 32'(irq), 32'(IRQ_EN));

    // Reset mid-operation clears everything in one clock
    cyc(1'b1, 1'b0, 1'b1, 2'd3, 32'h0);
    check("t5_readdata", readdata, 32'h0);
    check("t5_irq", 32'(irq), 32'h0);
    rd(2'd3); check("t5_ecap", readdata, 32'h0);
    rd(2'd2); check("t5_mask", readdata, 32'h0);

    // All-ones mask write then an edge
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2); check("t6_mask", readdata, IRQ_EN ? 32'hF : 32'h0);
    cur_in = 4'h0; idle(5);
    cur_in = 4'h4; idle(5);
    rd(2'd3); check("t6_ecap", readdata, 32'h4);
    check("t6_irq", 32'(irq), 32'(IRQ_EN));

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      logic          r_rst, r_cs, r_wn;
      logic [1:0]    r_a;
      logic [31:0]   r_wd;
      if ($urandom_range(0, 3) == 0) cur_in = cur_in ^ DW'($urandom);
      r_rst = ($urandom_range(0, 99) == 0);
      r_cs  = 1'($urandom);
      r_wn  = ($urandom_range(0, 3) != 0);
      r_a   = 2'($urandom);
      r_wd  = $urandom;
      cyc(r_rst, r_cs, r_wn, r_a, r_wd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
